// File: rtl/john_lock_pkg.sv
// john_pkg: shared types and constants for the john_lock phase tracker.
//   state_t     - tracker state (HUNT, CHECK, LOCKED)
//   phase_t     - 3-bit phase index 0..7
//   xy_t        - one {x,y} sample from the Johnson generator decode
//   PAT         - expected {x,y} for each phase
//   ANCHOR_*    - the previous/current sample pair that marks phase 0
package john_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  typedef logic [2:0] phase_t;
  typedef logic [1:0] xy_t;

  // Element p holds PAT(p); element 0 is the rightmost entry.
  localparam logic [7:0][1:0] PAT = {
    2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00
  };

  localparam xy_t ANCHOR_PREV = 2'b01;
  localparam xy_t ANCHOR_CUR  = 2'b00;

  function automatic xy_t pat_at(input phase_t p);
    return PAT[p];
  endfunction

endpackage

// File: rtl/john_lock_if.sv
// john_lock_if: sample inputs and status outputs of the phase tracker.
//   x, y       - generator decode samples (master -> slave)
//   clr_err    - synchronous error-counter clear (master -> slave)
//   lock       - tracker is locked (slave -> master)
//   phase_vld  - phase output is meaningful (slave -> master)
//   phase      - phase of the most recent sample (slave -> master)
//   err        - one-cycle mismatch pulse while locked (slave -> master)
//   err_cnt    - saturating count of err pulses (slave -> master)
interface john_lock_if #(
  parameter int unsigned ERR_W = 8
) ();

  logic             x;
  logic             y;
  logic             clr_err;
  logic             lock;
  logic             phase_vld;
  logic [2:0]       phase;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output x, y, clr_err,
    input  lock, phase_vld, phase, err, err_cnt
  );

  modport slave (
    input  x, y, clr_err,
    output lock, phase_vld, phase, err, err_cnt
  );

endinterface

// File: rtl/john_lock_sat_cnt.sv
// sat_cnt: W-bit saturating event counter.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   inc  - count one event (ignored once the counter is at all-ones)
//   clr  - synchronous clear, takes priority over inc
//   cnt  - current count
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/john_lock.sv
// john_lock: recovers the 8-step phase of a 4-bit Johnson generator from
// its decoded x/y outputs, locks after LOCK_CNT consistent samples and
// flags pattern errors while locked.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - john_lock_if.slave: x, y, clr_err in; lock, phase_vld, phase,
//          err, err_cnt out (all outputs registered)
module john_lock
  import john_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned MISS_MAX = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  john_lock_if.slave  bus
);

  xy_t        cur;
  state_t     state_q;
  xy_t        prev_q;
  phase_t     phase_q;
  logic [3:0] match_cnt_q;
  logic [2:0] miss_cnt_q;
  logic       lock_q;
  logic       vld_q;
  logic       err_q;

  phase_t     phase_nxt;
  logic       anchor;
  logic       hit;
  logic [3:0] match_inc;
  logic [2:0] miss_inc;
  logic       err_d;
  logic [ERR_W-1:0] err_cnt;

  assign cur       = {bus.x, bus.y};
  assign phase_nxt = phase_q + 3'd1;
  assign anchor    = (prev_q == ANCHOR_PREV) && (cur == ANCHOR_CUR);
  // In CHECK and LOCKED the sample is always judged against the next phase.
  assign hit       = (cur == pat_at(phase_nxt));
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 3'd1;
  // Combinational so err_cnt increments on the same edge that raises err.
  assign err_d     = (state_q == LOCKED) && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      phase_q     <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      lock_q      <= 1'b0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_q <= cur;
      err_q  <= err_d;
      unique case (state_q)
        HUNT: begin
          if (anchor) begin
            state_q     <= CHECK;
            vld_q       <= 1'b1;
            phase_q     <= '0;
            match_cnt_q <= 4'd1;
          end
        end
        CHECK: begin
          if (hit) begin
            phase_q     <= phase_nxt;
            match_cnt_q <= match_inc;
            if (match_inc == 4'(LOCK_CNT)) begin
              state_q    <= LOCKED;
              lock_q     <= 1'b1;
              miss_cnt_q <= '0;
            end
          end else if (anchor) begin
            phase_q     <= '0;
            match_cnt_q <= 4'd1;
          end else begin
            state_q     <= HUNT;
            vld_q       <= 1'b0;
            match_cnt_q <= '0;
          end
        end
        LOCKED: begin
          // Flywheel: phase advances whatever the sample says.
          phase_q <= phase_nxt;
          if (hit) begin
            miss_cnt_q <= '0;
          end else begin
            miss_cnt_q <= miss_inc;
            if (miss_inc == 3'(MISS_MAX)) begin
              state_q     <= HUNT;
              lock_q      <= 1'b0;
              vld_q       <= 1'b0;
              match_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q <= HUNT;
          lock_q  <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(err_d),
    .clr(bus.clr_err),
    .cnt(err_cnt)
  );

  assign bus.lock      = lock_q;
  assign bus.phase_vld = vld_q;
  assign bus.phase     = phase_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_john_lock.sv
// Testbench for john_lock. Two instances share one sample stream: default
// parameters and ERR_W=2 (for counter saturation). A behavioural model
// tracks both and is compared every cycle; literal checks pin key points.
module tb_john_lock;

  localparam int LOCKN = 8;
  localparam int MISSN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  john_lock_if #(.ERR_W(8)) bus8 ();
  john_lock_if #(.ERR_W(2)) bus2 ();

  john_lock #(.LOCK_CNT(LOCKN), .MISS_MAX(MISSN), .ERR_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  john_lock #(.LOCK_CNT(LOCKN), .MISS_MAX(MISSN), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // {x,y} as an integer x*2+y for phases 0..7.
  const int PATV [8] = '{0, 2, 2, 0, 2, 2, 1, 1};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_prev = 0, m_ph = 0, m_mc = 0, m_miss = 0;
  bit m_lock = 0, m_vld = 0, m_err = 0;
  int e8 = 0, e2 = 0;

  task automatic model_step(input int s, input bit c, input bit r);
    bit anchor;
    bit fire;
    int n;
    if (r) begin
      m_prev = 0; m_ph = 0; m_mc = 0; m_miss = 0;
      m_lock = 0; m_vld = 0; m_err = 0; e8 = 0; e2 = 0;
      return;
    end
    anchor = (m_prev == 1) && (s == 0);
    n      = (m_ph + 1) % 8;
    fire   = 0;
    if (m_lock) begin
      m_ph = n;
      if (s == PATV[n]) m_miss = 0;
      else begin
        fire = 1;
        m_miss++;
        if (m_miss == MISSN) begin
          m_lock = 0; m_vld = 0; m_mc = 0;
        end
      end
    end else if (m_vld) begin
      if (s == PATV[n]) begin
        m_ph = n;
        m_mc++;
        if (m_mc == LOCKN) begin
          m_lock = 1; m_miss = 0;
        end
      end else if (anchor) begin
        m_ph = 0; m_mc = 1;
      end else begin
        m_vld = 0; m_mc = 0;
      end
    end else if (anchor) begin
      m_vld = 1; m_ph = 0; m_mc = 1;
    end
    m_err = fire;
    if (c) begin
      e8 = 0; e2 = 0;
    end else if (fire) begin
      if (e8 < 255) e8++;
      if (e2 < 3) e2++;
    end
    m_prev = s;
  endtask

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("lock8", bus8.lock, m_lock);
      chk("vld8", bus8.phase_vld, m_vld);
      chk("err8", bus8.err, m_err);
      chk("errcnt8", bus8.err_cnt, e8);
      chk("lock2", bus2.lock, m_lock);
      chk("vld2", bus2.phase_vld, m_vld);
      chk("err2", bus2.err, m_err);
      chk("errcnt2", bus2.err_cnt, e2);
      if (m_vld) begin
        chk("phase8", bus8.phase, m_ph);
        chk("phase2", bus2.phase, m_ph);
      end
    end
  end

  // ---------------- stimulus ----------------
  int gp = 0;

  task automatic cyc(input int s, input bit c = 1'b0, input bit r = 1'b0);
    logic [1:0] v;
    v = s[1:0];
    {bus8.x, bus8.y} = v;
    {bus2.x, bus2.y} = v;
    bus8.clr_err = c;
    bus2.clr_err = c;
    rst = r;
    @(posedge clk);
    model_step(s, c, r);
    @(negedge clk);
  endtask

  task automatic gen(input int n);
    repeat (n) begin
      cyc(PATV[gp]);
      gp = (gp + 1) % 8;
    end
  endtask

  task automatic bad(input int s, input bit c = 1'b0);
    cyc(s, c);
    gp = (gp + 1) % 8;
  endtask

  // Generator decode assumed as y = q3&~q1&~q0, x = (q0&~q2)|(q3&q2&q1),
  // which reproduces the x/y table on the legal Johnson loop.
  function automatic int decode(input logic [3:0] q);
    logic xv, yv;
    yv = q[3] & ~q[1] & ~q[0];
    xv = (q[0] & ~q[2]) | (q[3] & q[2] & q[1]);
    return {30'd0, xv, yv};
  endfunction

  logic [3:0] q;

  initial begin
    bus8.x = 0; bus8.y = 0; bus8.clr_err = 0;
    bus2.x = 0; bus2.y = 0; bus2.clr_err = 0;
    rst = 1;

    // Reset state
    cyc(0, 0, 1);
    cmp_en = 1;
    cyc(0, 0, 1);
    chk("rst_lock", bus8.lock, 0);
    chk("rst_vld", bus8.phase_vld, 0);
    chk("rst_phase", bus8.phase, 0);
    chk("rst_errcnt", bus8.err_cnt, 0);

    // Clean lock starting at phase 3: anchor is the sixth sample
    gp = 3;
    gen(6);
    chk("anchor_vld", bus8.phase_vld, 1);
    chk("anchor_phase", bus8.phase, 0);
    chk("anchor_lock", bus8.lock, 0);
    gen(6);
    chk("prelock", bus8.lock, 0);
    gen(1);
    chk("lock_at_A7", bus8.lock, 1);
    chk("lock_phase7", bus8.phase, 7);
    gen(10);

    // Single locked error on a phase-0 sample
    while (gp != 0) gen(1);
    bad(2);
    chk("single_err", bus8.err, 1);
    chk("single_errcnt", bus8.err_cnt, 1);
    chk("single_lock", bus8.lock, 1);
    chk("single_phase", bus8.phase, 0);
    gen(1);
    chk("single_err_drop", bus8.err, 0);
    chk("single_phase_next", bus8.phase, 1);

    // Loss of lock: two consecutive corrupted samples
    cyc(PATV[gp], 1);
    gp = (gp + 1) % 8;
    chk("clr_errcnt", bus8.err_cnt, 0);
    while (gp != 2) gen(1);
    bad(1);
    chk("loss1_lock", bus8.lock, 1);
    bad(3);
    chk("loss2_err", bus8.err, 1);
    chk("loss2_errcnt", bus8.err_cnt, 2);
    chk("loss2_lock", bus8.lock, 0);
    chk("loss2_vld", bus8.phase_vld, 0);
    gen(5);
    chk("reanchor_vld", bus8.phase_vld, 1);
    chk("reanchor_phase", bus8.phase, 0);
    gen(7);
    chk("relock", bus8.lock, 1);

    // Reset while locked
    cyc(PATV[gp], 0, 1);
    chk("mid_rst_lock", bus8.lock, 0);
    chk("mid_rst_vld", bus8.phase_vld, 0);
    chk("mid_rst_phase", bus8.phase, 0);
    chk("mid_rst_err", bus8.err, 0);
    chk("mid_rst_errcnt2", bus2.err_cnt, 0);

    // CHECK failure with a non-anchor sample at match count 4
    gp = 6;
    gen(6);
    chk("chk4_phase", bus8.phase, 3);
    bad(3);
    chk("chkfail_vld", bus8.phase_vld, 0);
    chk("chkfail_err", bus8.err, 0);
    chk("chkfail_errcnt", bus8.err_cnt, 0);

    // CHECK mismatch that is itself an anchor
    gen(4);
    gen(6);
    chk("chk6_phase", bus8.phase, 6);
    cyc(0);
    gp = 1;
    chk("reanc_phase", bus8.phase, 0);
    chk("reanc_vld", bus8.phase_vld, 1);
    chk("reanc_lock", bus8.lock, 0);
    gen(6);
    chk("reanc_prelock", bus8.lock, 0);
    gen(1);
    chk("reanc_lock7", bus8.lock, 1);

    // Saturation with ERR_W=2, then clear coincident with err
    cyc(PATV[gp], 1);
    gp = (gp + 1) % 8;
    repeat (5) begin
      bad(PATV[gp] ^ 3);
      gen(1);
    end
    chk("sat_errcnt2", bus2.err_cnt, 3);
    chk("sat_errcnt8", bus8.err_cnt, 5);
    chk("sat_lock", bus8.lock, 1);
    bad(PATV[gp] ^ 3, 1);
    chk("clrhit_err", bus8.err, 1);
    chk("clrhit_errcnt8", bus8.err_cnt, 0);
    chk("clrhit_errcnt2", bus2.err_cnt, 0);
    gen(2);

    // Reset then a generator stuck in the disallowed loop
    cyc(0, 0, 1);
    chk("rst2_lock", bus8.lock, 0);
    chk("rst2_vld", bus8.phase_vld, 0);
    q = 4'b0100;
    repeat (32) begin
      cyc(decode(q));
      q = {q[2:0], ~q[3]};
    end
    chk("stuck_lock", bus8.lock, 0);
    chk("stuck_vld", bus8.phase_vld, 0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
